endian_swap_stream: RTL

- Parametrised, pipelined successor to the fixed 48-bit combinational bit reverser.
- Streaming reorder stage with valid/ready handshake and a run-time-selectable reorder mode:
  - passthrough
  - full bit reverse
  - byte reverse
  - bit reverse within each byte
- Sits between packet/key datapaths in the security pipeline.
- A 2-entry skid buffer gives full throughput with registered ready.

---
 rtl/endian_swap_pkg.sv | 16 +
 rtl/endian_swap_xform.sv | 49 ++++
 rtl/endian_swap_stream.sv | 110 +++++++++++
 3 files changed

// File: rtl/endian_swap_pkg.sv
// endian_swap_pkg
//   Shared types and constants for the endian_swap_stream reorder stage.
//   - mode_t     : run-time reorder mode selector
//   - BEAT_CNT_W : width of the completed-beat counter
package endian_swap_pkg;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'b00,  // out = in
    MODE_BITREV    = 2'b01,  // full-word bit reverse
    MODE_BYTEREV   = 2'b10,  // byte order reversed, bits within a byte kept
    MODE_BITINBYTE = 2'b11   // bits reversed inside each byte, byte order kept
  } mode_t;

  localparam int BEAT_CNT_W = 16;

endpackage : endian_swap_pkg

// File: rtl/endian_swap_xform.sv
// endian_swap_xform
//   Pure combinational reorder of one DATA_W-bit word.
// Ports:
//   i_mode : reorder mode (mode_t)
//   i_data : input word
//   o_data : reordered word
module endian_swap_xform
  import endian_swap_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  mode_t             i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] w_bitrev;
  logic [DATA_W-1:0] w_byterev;
  logic [DATA_W-1:0] w_bitinbyte;

  genvar gi, gj;

  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bitrev
      assign w_bitrev[gi] = i_data[DATA_W-1-gi];
    end

    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign w_byterev[8*gi +: 8] = i_data[8*(NBYTES-1-gi) +: 8];
      for (gj = 0; gj < 8; gj++) begin : g_bit
        assign w_bitinbyte[8*gi+gj] = i_data[8*gi+7-gj];
      end
    end
  endgenerate

  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_PASS:      o_data = i_data;
      MODE_BITREV:    o_data = w_bitrev;
      MODE_BYTEREV:   o_data = w_byterev;
      MODE_BITINBYTE: o_data = w_bitinbyte;
      default:        o_data = i_data;
    endcase
  end

endmodule : endian_swap_xform

// File: rtl/endian_swap_stream.sv
// endian_swap_stream
//   Streaming reorder stage: valid/ready handshake, 2-entry skid buffer
//   (main register drives the output, skid register absorbs one beat when
//   the output stalls), run-time selectable reorder mode, beat counter.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_valid/cfg_mode    : mode load request; accepted only when cfg_ready
//   cfg_ready             : pipeline empty and no input pending
//   mode                  : currently active mode
//   in_valid/in_ready/in_data    : upstream beat interface
//   out_valid/out_ready/out_data : downstream beat interface
//   beat_count            : completed output beats, wraps
module endian_swap_stream
  import endian_swap_pkg::*;
#(
  parameter int          DATA_W     = 48,
  parameter logic [1:0]  RESET_MODE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [1:0]            cfg_mode,
  output logic                  cfg_ready,
  output logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [BEAT_CNT_W-1:0] beat_count
);

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
      $error("endian_swap_stream: DATA_W must be a multiple of 8 and >= 8");
    end
  endgenerate

  mode_t                 r_mode;
  logic                  r_main_valid;
  logic [DATA_W-1:0]     r_main_data;
  logic                  r_skid_valid;
  logic [DATA_W-1:0]     r_skid_data;
  logic [BEAT_CNT_W-1:0] r_beat_count;

  logic [DATA_W-1:0]     w_xform_data;
  logic                  w_consume;
  logic                  w_cfg_load;

  endian_swap_xform #(
    .DATA_W (DATA_W)
  ) u_xform (
    .i_mode (r_mode),
    .i_data (in_data),
    .o_data (w_xform_data)
  );

  // in_ready comes straight from a flop: open whenever the skid slot is free.
  assign in_ready   = ~r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign mode       = r_mode;
  assign beat_count = r_beat_count;

  assign w_consume  = r_main_valid & out_ready;
  // Config only when nothing is buffered and nothing is arriving, so the
  // mode can never change underneath a beat; data wins over config.
  assign cfg_ready  = ~r_main_valid & ~r_skid_valid & ~in_valid;
  assign w_cfg_load = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= mode_t'(RESET_MODE);
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_beat_count <= '0;
    end else begin
      if (w_cfg_load) begin
        r_mode <= mode_t'(cfg_mode);
      end

      if (w_consume) begin
        r_beat_count <= r_beat_count + BEAT_CNT_W'(1);
      end

      if (r_skid_valid) begin
        // in_ready is low here, so no accept; refill main from skid when
        // the main beat leaves.
        if (out_ready) begin
          r_main_data  <= r_skid_data;
          r_skid_valid <= 1'b0;
        end
      end else if (!r_main_valid || out_ready) begin
        // Main is free (or freeing this edge): new beat lands in main.
        r_main_valid <= in_valid;
        if (in_valid) begin
          r_main_data <= w_xform_data;
        end
      end else if (in_valid) begin
        // Main stalled with a beat: park the new one in skid.
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_xform_data;
      end
    end
  end

endmodule : endian_swap_stream
